// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and constants for the sram-like memory port arbiter.
//   arb_state_e : FSM encoding (IDLE -> REQ -> WAIT)
//   owner_e     : which requester owns the in-flight transaction
//   SZ_*        : transfer size codes on d_size / m_size
//   other_owner : helper returning the opposite requester
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic owner_e other_owner(input owner_e o);
    if (o == OWN_INST) begin
      return OWN_DATA;
    end else begin
      return OWN_INST;
    end
  endfunction

endpackage

// File: rtl/sram_like_arbiter_arb_pick.sv
// Combinational two-way picker for the sram-like arbiter.
// Build option: define SRAM_ARB_RR_EN for round-robin tie breaking; otherwise
// data wins every tie so a stalled MEM access can never be starved by fetches.
// Ports:
//   i_req, d_req : pending requests from the inst and data sides
//   rr_last      : owner of the most recent grant (round-robin history)
//   grant_inst   : inst side wins this cycle
//   grant_data   : data side wins this cycle
module arb_pick
  import sram_like_arbiter_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  owner_e rr_last,
  output logic   grant_inst,
  output logic   grant_data
);

`ifdef SRAM_ARB_RR_EN
  // Round-robin: on a tie the side that did not win last time goes first.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (i_req && d_req) begin
      if (rr_last == OWN_DATA) begin
        grant_inst = 1'b1;
      end else begin
        grant_data = 1'b1;
      end
    end else begin
      grant_inst = i_req;
      grant_data = d_req;
    end
  end
`else
  // History is irrelevant with fixed priority.
  logic unused_rr_last;
  assign unused_rr_last = rr_last;

  // Fixed priority: data beats inst on every tie.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (d_req) begin
      grant_data = 1'b1;
    end else begin
      grant_inst = i_req;
    end
  end
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like downstream port between the IF (read-only) and MEM
// (read/write) requesters. One transaction in flight at a time; the FSM walks
// IDLE (grant + latch payload) -> REQ (address phase) -> WAIT (data phase).
// A flushed fetch still completes downstream but its response is swallowed.
// Build option: SRAM_ARB_RR_EN selects round-robin tie breaking (see arb_pick).
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   i_req/i_addr               : inst request (held until i_addr_ok)
//   i_addr_ok/i_data_ok/i_rdata: inst accept / response / read data
//   i_cancel                   : drop the response of the inst fetch in flight
//   d_req/d_wr/d_size/d_wstrb/d_addr/d_wdata : data request and payload
//   d_addr_ok/d_data_ok/d_rdata: data accept / response / read data
//   m_req/m_wr/m_size/m_wstrb/m_addr/m_wdata : downstream request and payload
//   m_addr_ok/m_data_ok/m_rdata: downstream accept / response / read data
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_addr_ok,
  output logic            i_data_ok,
  output logic [DW-1:0]   i_rdata,
  input  logic            i_cancel,
  input  logic            d_req,
  input  logic            d_wr,
  input  logic [1:0]      d_size,
  input  logic [DW/8-1:0] d_wstrb,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_addr_ok,
  output logic            d_data_ok,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_wr,
  output logic [1:0]      m_size,
  output logic [DW/8-1:0] m_wstrb,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic            m_addr_ok,
  input  logic            m_data_ok,
  input  logic [DW-1:0]   m_rdata
);

  arb_state_e state_r, state_nxt_s;
  owner_e     owner_r, rr_last_r;
  logic       drop_r;
  logic       grant_inst_s, grant_data_s;
  logic       resp_s;

  arb_pick u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .rr_last    (rr_last_r),
    .grant_inst (grant_inst_s),
    .grant_data (grant_data_s)
  );

  // Read data is a straight passthrough; data_ok is the qualifier.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

  // Next-state and handshake decode.
  always_comb begin
    state_nxt_s = state_r;
    i_addr_ok   = 1'b0;
    d_addr_ok   = 1'b0;
    m_req       = 1'b0;
    resp_s      = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        i_addr_ok = grant_inst_s;
        d_addr_ok = grant_data_s;
        if (grant_inst_s || grant_data_s) begin
          state_nxt_s = ARB_REQ;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        m_req = 1'b1;
        // Address and data accepted together: the transaction is done.
        if (m_addr_ok && m_data_ok) begin
          resp_s      = 1'b1;
          state_nxt_s = ARB_IDLE;
        end else if (m_addr_ok) begin
          state_nxt_s = ARB_WAIT;
        end else begin
          state_nxt_s = ARB_REQ;
        end
      end
      ARB_WAIT: begin
        if (m_data_ok) begin
          resp_s      = 1'b1;
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_WAIT;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // Route the response to the owner only; a cancel in the response cycle
  // itself is honoured too so a flushed fetch never leaks through.
  always_comb begin
    i_data_ok = 1'b0;
    d_data_ok = 1'b0;
    if (resp_s) begin
      i_data_ok = (owner_r == OWN_INST) && !drop_r && !i_cancel;
      d_data_ok = (owner_r == OWN_DATA);
    end else begin
      i_data_ok = 1'b0;
      d_data_ok = 1'b0;
    end
  end

  // State register, payload latch, ownership and cancel tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ARB_IDLE;
      owner_r   <= OWN_INST;
      rr_last_r <= OWN_DATA;
      drop_r    <= 1'b0;
      m_wr      <= 1'b0;
      m_size    <= 2'd0;
      m_wstrb   <= '0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ARB_IDLE: begin
          if (grant_data_s) begin
            owner_r   <= OWN_DATA;
            rr_last_r <= OWN_DATA;
            m_wr      <= d_wr;
            m_size    <= d_size;
            m_wstrb   <= d_wstrb;
            m_addr    <= d_addr;
            m_wdata   <= d_wdata;
            drop_r    <= 1'b0;
          end else if (grant_inst_s) begin
            // Fetches are always full-word reads.
            owner_r   <= OWN_INST;
            rr_last_r <= OWN_INST;
            m_wr      <= 1'b0;
            m_size    <= SZ_WORD;
            m_wstrb   <= '0;
            m_addr    <= i_addr;
            m_wdata   <= '0;
            drop_r    <= i_cancel;
          end else begin
            drop_r    <= 1'b0;
          end
        end
        ARB_REQ, ARB_WAIT: begin
          if (resp_s) begin
            drop_r <= 1'b0;
          end else if (owner_r == OWN_INST && i_cancel) begin
            drop_r <= 1'b1;
          end else begin
            drop_r <= drop_r;
          end
        end
        default: begin
          drop_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter. Inputs change 1 ns
// after the rising edge; outputs are sampled 1 ns later, mid-cycle.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, i_cancel, d_req, d_wr;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [1:0]  d_size;
  logic [3:0]  d_wstrb;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sram_like_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok),
    .i_data_ok(i_data_ok), .i_rdata(i_rdata), .i_cancel(i_cancel),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_wstrb(d_wstrb),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_addr_ok(d_addr_ok),
    .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
    .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called in the first REQ cycle: address phase, then response in WAIT.
  task automatic serve(input string tag, input logic [31:0] rd, input logic exp_i, input logic exp_d);
    m_addr_ok = 1'b1;
    #1;
    check({tag, "_mreq"}, 32'(m_req), 32'd1);
    step();
    m_addr_ok = 1'b0;
    m_data_ok = 1'b1;
    m_rdata   = rd;
    #1;
    check({tag, "_mreq_wait"}, 32'(m_req), 32'd0);
    check({tag, "_i_data_ok"}, 32'(i_data_ok), 32'(exp_i));
    check({tag, "_d_data_ok"}, 32'(d_data_ok), 32'(exp_d));
    check({tag, "_rdata"}, exp_i ? i_rdata : d_rdata, rd);
    step();
    m_data_ok = 1'b0;
    m_rdata   = 32'd0;
  endtask

  logic exp2_inst;

  initial begin
    rst_n = 1'b0; i_req = 1'b0; i_cancel = 1'b0; d_req = 1'b0; d_wr = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; d_size = 2'd0;
    d_wstrb = 4'd0; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = 32'd0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("rst_mreq", 32'(m_req), 32'd0);
    check("rst_iaok", 32'(i_addr_ok), 32'd0);
    check("rst_daok", 32'(d_addr_ok), 32'd0);
    check("rst_maddr", m_addr, 32'd0);
    check("rst_dok", 32'({i_data_ok, d_data_ok}), 32'd0);
    step();

    // 1: inst read
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    #1;
    check("t1_iaok", 32'(i_addr_ok), 32'd1);
    check("t1_daok", 32'(d_addr_ok), 32'd0);
    step();
    i_req = 1'b0;
    check("t1_maddr", m_addr, 32'hBFC0_0000);
    check("t1_mwr", 32'(m_wr), 32'd0);
    check("t1_msize", 32'(m_size), 32'd2);
    serve("t1", 32'h2408_0001, 1'b1, 1'b0);

    // 2: tie, two transactions (rr history now = inst)
    i_req = 1'b1; i_addr = 32'hBFC0_0010;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_1000; d_size = 2'd2; d_wstrb = 4'hF;
    #1;
    check("t2a_daok", 32'(d_addr_ok), 32'd1);
    check("t2a_iaok", 32'(i_addr_ok), 32'd0);
    step();
    check("t2a_iaok_req", 32'(i_addr_ok), 32'd0);
    check("t2a_maddr", m_addr, 32'h0000_1000);
    serve("t2a", 32'h0000_00A1, 1'b0, 1'b1);
`ifdef SRAM_ARB_RR_EN
    exp2_inst = 1'b1;
`else
    exp2_inst = 1'b0;
`endif
    #1;
    check("t2b_iaok", 32'(i_addr_ok), 32'(exp2_inst));
    check("t2b_daok", 32'(d_addr_ok), 32'(!exp2_inst));
    step();
    if (exp2_inst) begin
      i_req = 1'b0;
    end else begin
      d_req = 1'b0;
    end
    check("t2b_maddr", m_addr, exp2_inst ? 32'hBFC0_0010 : 32'h0000_1000);
    serve("t2b", 32'h0000_00B2, exp2_inst, !exp2_inst);
    // The loser of round two is granted now.
    #1;
    check("t2c_iaok", 32'(i_addr_ok), 32'(!exp2_inst));
    check("t2c_daok", 32'(d_addr_ok), 32'(exp2_inst));
    step();
    i_req = 1'b0; d_req = 1'b0;
    serve("t2c", 32'h0000_00C3, !exp2_inst, exp2_inst);

    // 3: data byte write
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'd0; d_wstrb = 4'b0100;
    d_addr = 32'h1FAF_0002; d_wdata = 32'h00AB_0000;
    #1;
    check("t3_daok", 32'(d_addr_ok), 32'd1);
    step();
    d_req = 1'b0;
    check("t3_mwr", 32'(m_wr), 32'd1);
    check("t3_msize", 32'(m_size), 32'd0);
    check("t3_mwstrb", 32'(m_wstrb), 32'h4);
    check("t3_maddr", m_addr, 32'h1FAF_0002);
    check("t3_mwdata", m_wdata, 32'h00AB_0000);
    serve("t3", 32'h0000_0000, 1'b0, 1'b1);
    d_wr = 1'b0;

    // 4: cancel during WAIT, then a normal fetch
    i_req = 1'b1; i_addr = 32'hBFC0_0004;
    step();
    i_req = 1'b0; m_addr_ok = 1'b1;
    step();
    m_addr_ok = 1'b0; i_cancel = 1'b1;
    step();
    i_cancel = 1'b0; m_data_ok = 1'b1; m_rdata = 32'hDEAD_BEEF;
    #1;
    check("t4_drop", 32'(i_data_ok), 32'd0);
    check("t4_drop_d", 32'(d_data_ok), 32'd0);
    step();
    m_data_ok = 1'b0;
    i_req = 1'b1; i_addr = 32'hBFC0_0008;
    #1;
    check("t4_idle_iaok", 32'(i_addr_ok), 32'd1);
    step();
    i_req = 1'b0;
    check("t4_maddr", m_addr, 32'hBFC0_0008);
    serve("t4", 32'h1111_2222, 1'b1, 1'b0);

    // 4b: cancel in the accept cycle
    i_req = 1'b1; i_addr = 32'hBFC0_000C; i_cancel = 1'b1;
    step();
    i_req = 1'b0; i_cancel = 1'b0;
    serve("t4b", 32'h3333_4444, 1'b0, 1'b0);

    // 5: slow slave, then same-cycle addr_ok/data_ok
    d_req = 1'b1; d_wr = 1'b0; d_size = 2'd1; d_wstrb = 4'b0011; d_addr = 32'h0000_2000;
    step();
    d_req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t5_hold_mreq", 32'(m_req), 32'd1);
      check("t5_hold_maddr", m_addr, 32'h0000_2000);
      check("t5_hold_msize", 32'(m_size), 32'd1);
      step();
    end
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h0000_55AA;
    #1;
    check("t5_same_dok", 32'(d_data_ok), 32'd1);
    check("t5_same_rdata", d_rdata, 32'h0000_55AA);
    step();
    m_addr_ok = 1'b0; m_data_ok = 1'b0;
    check("t5_back_idle", 32'(m_req), 32'd0);
    d_req = 1'b1;
    #1;
    check("t5_next_daok", 32'(d_addr_ok), 32'd1);
    step();
    d_req = 1'b0;
    serve("t5b", 32'h0000_0077, 1'b0, 1'b1);

    // 6: reset while in WAIT, then a stray response
    i_req = 1'b1; i_addr = 32'hBFC0_0020;
    step();
    i_req = 1'b0; m_addr_ok = 1'b1;
    step();
    m_addr_ok = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("t6_mreq", 32'(m_req), 32'd0);
    check("t6_maddr", m_addr, 32'd0);
    check("t6_msize", 32'(m_size), 32'd0);
    check("t6_aok", 32'({i_addr_ok, d_addr_ok}), 32'd0);
    m_data_ok = 1'b1; m_rdata = 32'hCAFE_F00D;
    #1;
    check("t6_stray_i", 32'(i_data_ok), 32'd0);
    check("t6_stray_d", 32'(d_data_ok), 32'd0);
    step();
    m_data_ok = 1'b0;
    i_req = 1'b1; i_addr = 32'hBFC0_0024;
    step();
    i_req = 1'b0;
    check("t6_after_maddr", m_addr, 32'hBFC0_0024);
    serve("t6", 32'h0BAD_CAFE, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
